// File: rtl/seg_disp_sched_pkg.sv
// Shared encodings for the segment display page scheduler: FSM states,
// page codes, decimal-point patterns and the dwell counter width.
package seg_disp_sched_pkg;

    localparam logic [1:0] ST_TIME = 2'd0;
    localparam logic [1:0] ST_DATE = 2'd1;
    localparam logic [1:0] ST_MSG  = 2'd2;

    localparam logic [1:0] PAGE_TIME = 2'd0;
    localparam logic [1:0] PAGE_DATE = 2'd1;
    localparam logic [1:0] PAGE_MSG  = 2'd2;

    // hh.mm.ss / yy.mm.dd separators sit after digits 4 and 2
    localparam logic [5:0] POINT_SEP  = 6'b010100;
    localparam logic [5:0] POINT_NONE = 6'b000000;

    localparam int DWELL_W = 16;

    function automatic logic [1:0] page_of(input logic [1:0] st);
        case (st)
            ST_TIME: page_of = PAGE_TIME;
            ST_DATE: page_of = PAGE_DATE;
            default: page_of = PAGE_MSG;
        endcase
    endfunction

endpackage

// File: rtl/seg_disp_sched_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_FREQ/1000 clocks; clr
// restarts the period so a tick lands exactly one full ms after a restart.
module ms_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Rotates a 6-digit display between TIME and DATE pages and lets a
// message request preempt either page for a fixed dwell.
module seg_disp_sched
    import seg_disp_sched_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TIME_MS  = 8000,
    parameter int DATE_MS  = 2000,
    parameter int MSG_MS   = 3000,
    parameter int BLINK_MS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] time_num,
    input  logic [23:0] date_num,
    input  logic        msg_req,
    input  logic [23:0] msg_num,
    input  logic [5:0]  msg_point,
    output logic [23:0] num,
    output logic [5:0]  point,
    output logic [1:0]  page,
    output logic        msg_busy
);

    localparam logic [DWELL_W-1:0] TIME_LAST  = DWELL_W'(TIME_MS - 1);
    localparam logic [DWELL_W-1:0] DATE_LAST  = DWELL_W'(DATE_MS - 1);
    localparam logic [DWELL_W-1:0] MSG_LAST   = DWELL_W'(MSG_MS - 1);
    localparam logic [DWELL_W-1:0] BLINK_LAST = DWELL_W'(BLINK_MS - 1);

    logic [1:0]         state;
    logic [1:0]         ret_page;   // state code of the page a message interrupted
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_last;
    logic [DWELL_W-1:0] blink_cnt;
    logic               blink_on;
    logic [23:0]        msg_num_q;
    logic [5:0]         msg_point_q;
    logic               dwell_tick;
    logic               blink_tick;
    logic               expire;
    logic               restart;

    // NOTE: the default arm assigns dwell_last on every path, so no latch.
    always_comb begin
        case (state)
            ST_TIME: dwell_last = TIME_LAST;
            ST_DATE: dwell_last = DATE_LAST;
            default: dwell_last = MSG_LAST;
        endcase
    end

    assign expire  = dwell_tick && (dwell == dwell_last);
    assign restart = msg_req || expire;

    // Dwell timebase restarts on page entry; blink timebase never does.
    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_dwell_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .tick  (dwell_tick)
    );

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_blink_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .tick  (blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_TIME;
            ret_page    <= ST_TIME;
            dwell       <= '0;
            msg_num_q   <= '0;
            msg_point_q <= '0;
        end else if (msg_req) begin
            if (state != ST_MSG) ret_page <= state;
            state       <= ST_MSG;
            dwell       <= '0;
            msg_num_q   <= msg_num;
            msg_point_q <= msg_point;
        end else if (expire) begin
            dwell <= '0;
            case (state)
                ST_TIME: state <= ST_DATE;
                ST_DATE: state <= ST_TIME;
                default: state <= ret_page;
            endcase
        end else if (dwell_tick) begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num      <= '0;
            point    <= '0;
            page     <= PAGE_TIME;
            msg_busy <= 1'b0;
        end else begin
            page     <= page_of(state);
            msg_busy <= (state == ST_MSG);
            case (state)
                ST_TIME: begin
                    num   <= time_num;
                    point <= blink_on ? POINT_SEP : POINT_NONE;
                end
                ST_DATE: begin
                    num   <= date_num;
                    point <= POINT_SEP;
                end
                default: begin
                    num   <= msg_num_q;
                    point <= msg_point_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched: directed page scenarios plus random
// message traffic, compared against a cycle-countdown page model.
module tb_seg_disp_sched;

    localparam int TICK_CYC  = 10;
    localparam int TIME_CYC  = 8 * TICK_CYC;
    localparam int DATE_CYC  = 2 * TICK_CYC;
    localparam int MSG_CYC   = 3 * TICK_CYC;
    localparam int BLINK_CYC = 5 * TICK_CYC;
    localparam logic [5:0] SEP = 6'b010100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] time_num = '0;
    logic [23:0] date_num = '0;
    logic        msg_req = 1'b0;
    logic [23:0] msg_num = '0;
    logic [5:0]  msg_point = '0;
    logic [23:0] num;
    logic [5:0]  point;
    logic [1:0]  page;
    logic        msg_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: page shown, cycles left on it, interrupted page, message latch.
    int          m_page;
    int          m_left;
    int          m_ret;
    int          m_cyc;
    logic [23:0] m_msg_num;
    logic [5:0]  m_msg_pt;

    seg_disp_sched #(
        .CLK_FREQ (10_000),
        .TIME_MS  (8),
        .DATE_MS  (2),
        .MSG_MS   (3),
        .BLINK_MS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .time_num  (time_num),
        .date_num  (date_num),
        .msg_req   (msg_req),
        .msg_num   (msg_num),
        .msg_point (msg_point),
        .num       (num),
        .point     (point),
        .page      (page),
        .msg_busy  (msg_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_page    = 0;
        m_left    = TIME_CYC;
        m_ret     = 0;
        m_cyc     = 0;
        m_msg_num = '0;
        m_msg_pt  = '0;
    endtask

    // Called at a negedge: asserts reset, checks cleared outputs, releases.
    task automatic do_reset();
        rst_n   = 1'b0;
        msg_req = 1'b0;
        #1;
        check("rst_num", 32'(num), 32'd0);
        check("rst_point", 32'(point), 32'd0);
        check("rst_page", 32'(page), 32'd0);
        check("rst_busy", 32'(msg_busy), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_num", 32'(num), 32'd0);
            check("rst_hold_page", 32'(page), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic req, input logic [23:0] mn, input logic [5:0] mp);
        logic [23:0] e_num;
        logic [5:0]  e_pt;
        int          e_page;
        msg_req   = req;
        msg_num   = mn;
        msg_point = mp;
        @(posedge clk);
        e_page = m_page;
        case (m_page)
            0: begin
                e_num = time_num;
                e_pt  = (((m_cyc / BLINK_CYC) % 2) == 0) ? SEP : 6'b000000;
            end
            1: begin
                e_num = date_num;
                e_pt  = SEP;
            end
            default: begin
                e_num = m_msg_num;
                e_pt  = m_msg_pt;
            end
        endcase
        if (req) begin
            if (m_page != 2) m_ret = m_page;
            m_page    = 2;
            m_left    = MSG_CYC;
            m_msg_num = mn;
            m_msg_pt  = mp;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_page == 0) begin
                    m_page = 1;
                    m_left = DATE_CYC;
                end else if (m_page == 1) begin
                    m_page = 0;
                    m_left = TIME_CYC;
                end else begin
                    m_page = m_ret;
                    m_left = (m_ret == 0) ? TIME_CYC : DATE_CYC;
                end
            end
        end
        m_cyc++;
        #1;
        check("num", 32'(num), 32'(e_num));
        check("point", 32'(point), 32'(e_pt));
        check("page", 32'(page), 32'(e_page));
        check("busy", 32'(msg_busy), 32'(e_page == 2));
        @(negedge clk);
        msg_req = 1'b0;
    endtask

    task automatic step_idle();
        step(1'b0, 24'($urandom), 6'($urandom));
    endtask

    // Length of the current run of identical observed page values.
    task automatic run_len(output int n);
        logic [1:0] p;
        p = page;
        n = 1;
        step_idle();
        while (page == p && n < 300) begin
            n++;
            step_idle();
        end
    endtask

    task automatic wait_model(input int pg, input int left);
        int g;
        g = 0;
        while (!(m_page == pg && m_left == left) && g < 300) begin
            step_idle();
            g++;
        end
        check("wait_timeout", 32'(g < 300), 32'd1);
    endtask

    initial begin
        int n;
        model_reset();
        time_num = 24'h123456;
        date_num = 24'h240517;
        #2;
        do_reset();

        // Rotation
        step_idle();
        run_len(n);
        check("time_dwell", 32'(n), 32'(TIME_CYC));
        check("date_entry_num", 32'(num), 32'h240517);
        run_len(n);
        check("date_dwell", 32'(n), 32'(DATE_CYC));
        check("back_to_time", 32'(page), 32'd0);

        // Preempt DATE at its cycle 5
        wait_model(1, DATE_CYC - 5);
        step(1'b1, 24'h000042, 6'b000001);
        step_idle();
        check("pre_page", 32'(page), 32'd2);
        check("pre_num", 32'(num), 32'h000042);
        check("pre_point", 32'(point), 32'b000001);
        run_len(n);
        check("pre_msg_dwell", 32'(n), 32'(MSG_CYC));
        check("pre_ret_date", 32'(page), 32'd1);
        run_len(n);
        check("pre_fresh_date", 32'(n), 32'(DATE_CYC));

        // Retrigger from TIME, 20 cycles into MSG
        step(1'b1, 24'($urandom), 6'($urandom));
        step_idle();
        wait_model(2, MSG_CYC - 20);
        step(1'b1, 24'h999999, 6'b100001);
        step_idle();
        check("retrig_num", 32'(num), 32'h999999);
        run_len(n);
        check("retrig_dwell", 32'(n), 32'(MSG_CYC));
        check("retrig_ret_time", 32'(page), 32'd0);

        // Collision with TIME expiry
        wait_model(0, 1);
        step(1'b1, 24'h314159, 6'b000010);
        step_idle();
        check("coll_page", 32'(page), 32'd2);
        run_len(n);
        check("coll_dwell", 32'(n), 32'(MSG_CYC));
        check("coll_ret_time", 32'(page), 32'd0);

        // Reset mid-MSG
        step(1'b1, 24'h777777, 6'b111111);
        repeat (5) step_idle();
        check("mid_msg_page", 32'(page), 32'd2);
        do_reset();
        step_idle();
        check("post_rst_page", 32'(page), 32'd0);
        run_len(n);
        check("post_rst_time_dwell", 32'(n), 32'(TIME_CYC));
        check("post_rst_date", 32'(page), 32'd1);

        // Random traffic with live-changing inputs
        for (int i = 0; i < 1500; i++) begin
            time_num = 24'($urandom);
            date_num = 24'($urandom);
            step(($urandom_range(0, 29) == 0), 24'($urandom), 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
